ibex_mem_arbiter: RTL and testbench
===================================

IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted transactions awaiting rvalid (legal range 1..8).
REQ-002 SHALL have ports: clk_i  input  1  sole clock, all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 instr_req_i  input  1  core instruction-fetch request.
REQ-005 instr_gnt_o  output  1  instruction request accepted.
REQ-006 instr_rvalid_o  output  1  response on the rsp_* lines belongs to instruction side.
REQ-007 instr_addr_i  input  32  fetch address.
REQ-008 data_req_i  input  1  core load/store request.
REQ-009 data_gnt_o  output  1  data request accepted.
REQ-010 data_rvalid_o  output  1  response on the rsp_* lines belongs to data side.
REQ-011 data_we_i  input  1  store when 1.
REQ-012 data_be_i  input  4  byte enables.
REQ-013 data_addr_i  input  32  load/store address.
REQ-014 data_wdata_i  input  32  store data.
REQ-015 data_wdata_intg_i  input  7  store data integrity bits.
REQ-016 rsp_rdata_o  output  32  response read data, shared by both sides.
REQ-017 rsp_rdata_intg_o  output  7  response integrity bits, shared.
REQ-018 rsp_err_o  output  1  response error, valid only with instr_rvalid_o or data_rvalid_o.
REQ-019 mem_req_o  output  1  request to the single shared memory port.
REQ-020 mem_gnt_i  input  1  memory accepts request.
REQ-021 mem_rvalid_i  input  1  memory response valid, in grant order.
REQ-022 mem_we_o  output  1  write enable.
REQ-023 mem_be_o  output  4  byte enables.
REQ-024 mem_addr_o  output  32  address.
REQ-025 mem_wdata_o  output  32  write data.
REQ-026 mem_wdata_intg_o  output  7  write integrity bits.
REQ-027 mem_rdata_i  input  32  read data.
REQ-028 mem_rdata_intg_i  input  7  read integrity bits.
REQ-029 mem_err_i  input  1  response error.
REQ-030 alert_o  output  1  protocol-violation pulse (rvalid with no outstanding transaction).

Function
REQ-031 The arbiter SHALL keep an in-order source FIFO (depth MaxOutstanding, 1-bit entry: 0=instr, 1=data) plus a count of width $clog2(MaxOutstanding+1).
REQ-032 mem_req_o SHALL equal (instr_req_i | data_req_i) & ~full; when the FIFO is full, mem_req_o and both gnt outputs SHALL be 0, even if mem_rvalid_i is high in the same cycle.
REQ-033 Selection SHALL be round-robin: with both requests pending, the side not most recently granted wins; with one pending, that side wins.
REQ-034 Once mem_req_o is high without mem_gnt_i, the selected side SHALL be locked until the cycle mem_gnt_i is seen; the other side's request SHALL NOT change the selection.
REQ-035 Side gnt output = mem_gnt_i & mem_req_o & (selected == side); the non-selected gnt SHALL be 0; zero-cycle combinational path.
REQ-036 Instr selected: mem_addr_o=instr_addr_i, mem_we_o=0, mem_be_o=4'b1111, mem_wdata_o/mem_wdata_intg_o pass data_wdata_i/data_wdata_intg_i (don't-care to memory). Data selected: all mem_* pass data_* unchanged.
REQ-037 On a grant, the selected source ID SHALL be pushed and the round-robin pointer updated on the same clock edge.
REQ-038 On mem_rvalid_i with FIFO non-empty, the head SHALL be popped and the head side's rvalid asserted in the same cycle; rsp_* SHALL be mem_rdata_i, mem_rdata_intg_i, mem_err_i unmodified, zero latency.
REQ-039 Simultaneous push and pop SHALL leave count unchanged and preserve order; pointers wrap modulo MaxOutstanding.
REQ-040 mem_rvalid_i with FIFO empty SHALL produce no side rvalid, and alert_o SHALL be high for exactly the following cycle.

Reset
REQ-041 On rst_ni low: FIFO empty, count 0, lock clear, round-robin pointer set so data wins the first tie, alert_o 0; outstanding transactions are discarded, and late rvalids for them SHALL follow REQ-040.

Verification
REQ-042 Instr-only fetch, addr 0x100, gnt same cycle, rvalid 2 cycles later rdata 0xDEADBEEF -> instr_gnt_o=1 once, instr_rvalid_o=1 with rsp_rdata_o=0xDEADBEEF, data_rvalid_o never high.
REQ-043 Both requests held high every cycle, gnt always 1 -> grants alternate D,I,D,I; rvalids routed in the same order.
REQ-044 MaxOutstanding=2, two grants with no rvalid, third request pending -> mem_req_o=0 until the first rvalid, then one cycle after it goes high again.
REQ-045 Instr request stalled (gnt=0) for 3 cycles, data_req_i rises in cycle 2 -> mem_addr_o stays instr_addr_i until gnt, then data is granted next.
REQ-046 Store (be=4'b0011, wdata 0x1234) granted, rvalid with mem_err_i=1 -> data_rvalid_o=1, rsp_err_o=1; stray rvalid afterwards -> alert_o pulse 1 cycle, count stays 0.

Source files
------------

// File: rtl/ibex_mem_arbiter.sv
// Two-master (instr/data) arbiter onto one shared memory port.
// Round-robin with request lock, in-order response routing via a source FIFO.
module ibex_mem_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic [6:0]  data_wdata_intg_i,
   output logic [31:0] rsp_rdata_o,
   output logic [6:0]  rsp_rdata_intg_o,
   output logic        rsp_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [6:0]  mem_wdata_intg_o,
   input  logic [31:0] mem_rdata_i,
   input  logic [6:0]  mem_rdata_intg_i,
   input  logic        mem_err_i,
   output logic        alert_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [PtrW-1:0] PtrMax = PtrW'(MaxOutstanding - 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   // Source IDs: 0 = instr, 1 = data
   logic [MaxOutstanding-1:0] fifo_q, fifo_d;
   logic [PtrW-1:0]           wptr_q, wptr_d;
   logic [PtrW-1:0]           rptr_q, rptr_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      lock_q, lock_d;
   logic                      lock_sel_q, lock_sel_d;
   logic                      last_q, last_d;
   logic                      alert_q, alert_d;

   logic sel;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic head;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrMax) ? '0 : p + 1'b1;
   endfunction

   // Select a side, gate the memory request on FIFO space, mux the request fields
   always_comb begin
      full  = (cnt_q == CntMax);
      empty = (cnt_q == '0);
      if (lock_q) begin
         sel = lock_sel_q;
      end else if (instr_req_i && data_req_i) begin
         sel = ~last_q;
      end else begin
         sel = data_req_i;
      end
      mem_req_o   = (instr_req_i | data_req_i) & ~full;
      push        = mem_req_o & mem_gnt_i;
      instr_gnt_o = push & ~sel;
      data_gnt_o  = push & sel;
      mem_wdata_o      = data_wdata_i;
      mem_wdata_intg_o = data_wdata_intg_i;
      if (sel) begin
         mem_addr_o = data_addr_i;
         mem_we_o   = data_we_i;
         mem_be_o   = data_be_i;
      end else begin
         mem_addr_o = instr_addr_i;
         mem_we_o   = 1'b0;
         mem_be_o   = 4'b1111;
      end
   end

   // Route responses to the side at the FIFO head, zero latency
   always_comb begin
      pop              = mem_rvalid_i & ~empty;
      head             = fifo_q[rptr_q];
      instr_rvalid_o   = pop & ~head;
      data_rvalid_o    = pop & head;
      rsp_rdata_o      = mem_rdata_i;
      rsp_rdata_intg_o = mem_rdata_intg_i;
      rsp_err_o        = mem_err_i;
      alert_o          = alert_q;
   end

   // Next-state for FIFO, lock, round-robin pointer and alert
   always_comb begin
      fifo_d     = fifo_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      last_d     = last_q;
      alert_d    = mem_rvalid_i & empty;
      if (push) begin
         fifo_d[wptr_q] = sel;
         wptr_d         = ptr_inc(wptr_q);
         last_d         = sel;
         lock_d         = 1'b0;
      end else if (mem_req_o) begin
         lock_d     = 1'b1;
         lock_sel_d = sel;
      end
      if (pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // State registers; last_q=instr after reset so data wins the first tie
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
         last_q     <= 1'b0;
         alert_q    <= 1'b0;
      end else begin
         fifo_q     <= fifo_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
         last_q     <= last_d;
         alert_q    <= alert_d;
      end
   end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: directed literal scenarios, then
// randomized traffic against a queue-based reference model.
module tb_ibex_mem_arbiter;

   localparam int MO = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req, instr_gnt, instr_rvalid;
   logic [31:0] instr_addr;
   logic        data_req, data_gnt, data_rvalid, data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata;
   logic [6:0]  data_wintg;
   logic [31:0] rsp_rdata;
   logic [6:0]  rsp_intg;
   logic        rsp_err;
   logic        mem_req, mem_gnt, mem_rvalid, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [6:0]  mem_wintg, mem_rintg;
   logic        mem_err, alert;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ibex_mem_arbiter #(.MaxOutstanding(MO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(instr_req), .instr_gnt_o(instr_gnt),
      .instr_rvalid_o(instr_rvalid), .instr_addr_i(instr_addr),
      .data_req_i(data_req), .data_gnt_o(data_gnt),
      .data_rvalid_o(data_rvalid), .data_we_i(data_we),
      .data_be_i(data_be), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wintg),
      .rsp_rdata_o(rsp_rdata), .rsp_rdata_intg_o(rsp_intg),
      .rsp_err_o(rsp_err),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt),
      .mem_rvalid_i(mem_rvalid), .mem_we_o(mem_we),
      .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_wdata_intg_o(mem_wintg),
      .mem_rdata_i(mem_rdata), .mem_rdata_intg_i(mem_rintg),
      .mem_err_i(mem_err), .alert_o(alert)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      instr_req = 0; instr_addr = 0;
      data_req = 0; data_we = 0; data_be = 0; data_addr = 0;
      data_wdata = 0; data_wintg = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_rintg = 0;
      mem_err = 0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   // Reference model state
   bit mq[$];
   bit m_last;
   bit m_lock;
   bit m_lock_side;
   bit m_alert;
   bit hold_i, hold_d;

   initial begin
      rst_n = 1;
      idle();
      #2;
      do_reset();
      @(negedge clk);
      chk("reset_alert", alert, 0);
      chk("reset_req", mem_req, 0);
      next();

      // First tie after reset goes to data
      instr_req = 1; instr_addr = 32'h40;
      data_req = 1; data_addr = 32'h80; mem_gnt = 1;
      @(negedge clk);
      chk("tie_dgnt", data_gnt, 1);
      chk("tie_ignt", instr_gnt, 0);
      chk("tie_addr", mem_addr, 32'h80);
      next();
      idle(); mem_rvalid = 1;
      @(negedge clk);
      chk("tie_drv", data_rvalid, 1);
      next();

      // Instr-only fetch
      idle(); instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
      @(negedge clk);
      chk("f_ignt", instr_gnt, 1);
      chk("f_addr", mem_addr, 32'h100);
      chk("f_we", mem_we, 0);
      chk("f_be", mem_be, 4'hf);
      next();
      idle();
      @(negedge clk);
      chk("f_ignt_once", instr_gnt, 0);
      next();
      mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("f_irv", instr_rvalid, 1);
      chk("f_drv", data_rvalid, 0);
      chk("f_rdata", rsp_rdata, 32'hDEADBEEF);
      next();

      // Alternating grants and routed responses
      for (int k = 0; k <= 4; k++) begin
         idle();
         if (k < 4) begin
            instr_req = 1; instr_addr = 32'h1000 + k;
            data_req = 1; data_addr = 32'h2000 + k; mem_gnt = 1;
         end
         if (k > 0) begin
            mem_rvalid = 1; mem_rdata = k;
         end
         @(negedge clk);
         if (k < 4) begin
            chk("alt_dgnt", data_gnt, (k % 2 == 0));
            chk("alt_ignt", instr_gnt, (k % 2 == 1));
         end
         if (k > 0) begin
            chk("alt_drv", data_rvalid, ((k - 1) % 2 == 0));
            chk("alt_irv", instr_rvalid, ((k - 1) % 2 == 1));
         end
         next();
      end

      // Full FIFO blocks requests until a response frees a slot
      for (int k = 0; k < 6; k++) begin
         idle();
         if (k < 5) begin
            instr_req = 1; instr_addr = 32'h3000;
         end
         mem_gnt = (k < 4);
         mem_rvalid = (k == 3 || k == 4);
         @(negedge clk);
         case (k)
            0, 1: chk("full_gnt", instr_gnt, 1);
            2: begin
               chk("full_req", mem_req, 0);
               chk("full_ignt", instr_gnt, 0);
            end
            3: begin
               chk("full_req_rv", mem_req, 0);
               chk("full_irv", instr_rvalid, 1);
            end
            4: begin
               chk("full_req_again", mem_req, 1);
               chk("full_irv2", instr_rvalid, 1);
            end
            default: chk("full_idle", mem_req, 0);
         endcase
         next();
      end

      // Stalled instr request stays locked while data arrives
      for (int k = 0; k < 7; k++) begin
         idle();
         if (k < 5) begin
            instr_req = 1; instr_addr = 32'h200;
         end
         if (k >= 1 && k < 5) begin
            data_req = 1; data_addr = 32'h300;
         end
         mem_gnt = (k == 3 || k == 4);
         mem_rvalid = (k >= 5);
         @(negedge clk);
         if (k < 4) begin
            chk("lock_addr", mem_addr, 32'h200);
         end
         if (k < 3) begin
            chk("lock_dgnt", data_gnt, 0);
         end
         if (k == 3) chk("lock_ignt", instr_gnt, 1);
         if (k == 4) begin
            chk("lock_dgnt_next", data_gnt, 1);
            chk("lock_addr_d", mem_addr, 32'h300);
         end
         if (k == 5) chk("lock_irv", instr_rvalid, 1);
         if (k == 6) chk("lock_drv", data_rvalid, 1);
         next();
      end

      // Store with error, then a stray rvalid
      idle(); data_req = 1; data_we = 1; data_be = 4'b0011;
      data_addr = 32'h400; data_wdata = 32'h1234; data_wintg = 7'h55;
      mem_gnt = 1;
      @(negedge clk);
      chk("st_dgnt", data_gnt, 1);
      chk("st_we", mem_we, 1);
      chk("st_be", mem_be, 4'b0011);
      chk("st_wdata", mem_wdata, 32'h1234);
      chk("st_wintg", mem_wintg, 7'h55);
      next();
      idle(); mem_rvalid = 1; mem_err = 1;
      @(negedge clk);
      chk("st_drv", data_rvalid, 1);
      chk("st_err", rsp_err, 1);
      next();
      idle(); mem_rvalid = 1;
      @(negedge clk);
      chk("stray_drv", data_rvalid, 0);
      chk("stray_irv", instr_rvalid, 0);
      chk("stray_alert0", alert, 0);
      next();
      idle();
      @(negedge clk);
      chk("stray_alert1", alert, 1);
      next();
      idle(); mem_rvalid = 1;
      @(negedge clk);
      chk("stray_alert_off", alert, 0);
      chk("stray2_irv", instr_rvalid, 0);
      next();
      idle();
      @(negedge clk);
      chk("stray2_alert", alert, 1);
      next();

      // Randomized traffic against the reference model
      do_reset();
      mq.delete();
      m_last = 0; m_lock = 0; m_lock_side = 0; m_alert = 0;
      hold_i = 0; hold_d = 0;
      for (int c = 0; c < 3000; c++) begin
         bit full, ereq, side, pop, grant;
         if (!hold_i) begin
            instr_req = ($urandom_range(0, 9) < 6);
            instr_addr = $urandom;
         end
         if (!hold_d) begin
            data_req = ($urandom_range(0, 9) < 6);
            data_addr = $urandom; data_we = $urandom;
            data_be = $urandom; data_wdata = $urandom;
            data_wintg = $urandom;
         end
         mem_gnt = ($urandom_range(0, 2) != 0);
         if (mq.size() > 0) mem_rvalid = $urandom;
         else mem_rvalid = ($urandom_range(0, 19) == 0);
         mem_rdata = $urandom; mem_rintg = $urandom;
         mem_err = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         full = (mq.size() >= MO);
         ereq = (instr_req | data_req) & !full;
         if (m_lock) side = m_lock_side;
         else if (instr_req && data_req) side = !m_last;
         else side = data_req;
         grant = ereq & mem_gnt;
         pop = mem_rvalid && (mq.size() > 0);
         chk("r_req", mem_req, ereq);
         chk("r_ignt", instr_gnt, grant & !side);
         chk("r_dgnt", data_gnt, grant & side);
         chk("r_alert", alert, m_alert);
         if (ereq) begin
            chk("r_addr", mem_addr, side ? data_addr : instr_addr);
            chk("r_we", mem_we, side ? data_we : 1'b0);
            chk("r_be", mem_be, side ? data_be : 4'hf);
            chk("r_wdata", mem_wdata, data_wdata);
         end
         chk("r_irv", instr_rvalid, pop && mq[0] == 0);
         chk("r_drv", data_rvalid, pop && mq[0] == 1);
         if (pop) begin
            chk("r_rdata", rsp_rdata, mem_rdata);
            chk("r_rintg", rsp_intg, mem_rintg);
            chk("r_err", rsp_err, mem_err);
         end
         m_alert = mem_rvalid && (mq.size() == 0);
         if (pop) void'(mq.pop_front());
         if (grant) begin
            mq.push_back(side);
            m_last = side;
            m_lock = 0;
         end else if (ereq) begin
            m_lock = 1;
            m_lock_side = side;
         end
         hold_i = instr_req && !(grant && !side);
         hold_d = data_req && !(grant && side);
         next();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
